// File: rtl/seg7_capture.sv
// seg7_capture: samples a time-multiplexed 7-segment digit bus, debounces
// each {digit index, segment pattern} tuple, decodes it back to a nibble and
// assembles one nibble per digit position into a multi-digit word.
// Optional feature macro: SEG7_CAPTURE_CC_EN selects active-high
// (common-cathode) segment polarity; undefined means active-low.
//
// Input handshake: there is no back-pressure. A sample is consumed on every
// rising clk edge where seg_valid=1 and seg_idx<DIGITS; any other cycle is
// an idle cycle and breaks the current debounce run.
module seg7_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_valid,
    input  logic [IDX_W-1:0]      seg_idx,
    input  logic [6:0]            seg_n,
    output logic [4*DIGITS-1:0]   value,
    output logic                  frame_valid,
    output logic                  err,
    output logic [IDX_W-1:0]      err_idx,
    output logic [DIGITS-1:0]     pending
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } state_t;

    localparam logic [7:0] S8 = 8'(STABLE_CYCLES);

    state_t              state;
    logic [7:0]          cnt;
    logic [IDX_W-1:0]    cur_idx;
    logic [6:0]          cur_seg;
    logic [4*DIGITS-1:0] shadow;

    logic [6:0]          seg_al;
    logic                sample;
    logic                same;
    logic                accept;
    logic                dec_ok;
    logic [3:0]          dec_nib;
    logic [4*DIGITS-1:0] shadow_next;
    logic [DIGITS-1:0]   pend_set;
    logic [DIGITS-1:0]   pend_clr;

    // Normalise polarity so both tuple comparison and decode see active-low.
`ifdef SEG7_CAPTURE_CC_EN
    assign seg_al = ~seg_n;
`else
    assign seg_al = seg_n;
`endif

    assign sample = seg_valid && (32'(seg_idx) < DIGITS);
    assign same   = (seg_idx == cur_idx) && (seg_al == cur_seg);

    // Map an active-low abcdefg pattern to {valid, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = {1'b1, 4'h0};
            7'b1001111: decode = {1'b1, 4'h1};
            7'b0010010: decode = {1'b1, 4'h2};
            7'b0000110: decode = {1'b1, 4'h3};
            7'b1001100: decode = {1'b1, 4'h4};
            7'b0100100: decode = {1'b1, 4'h5};
            7'b0100000: decode = {1'b1, 4'h6};
            7'b0001111: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0000100: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b1100000: decode = {1'b1, 4'hB};
            7'b0110001: decode = {1'b1, 4'hC};
            7'b1000010: decode = {1'b1, 4'hD};
            7'b0110000: decode = {1'b1, 4'hE};
            7'b0111000: decode = {1'b1, 4'hF};
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    // Accept fires on the edge where the run of identical samples reaches STABLE_CYCLES.
    always_comb begin
        accept = 1'b0;
        case (state)
            IDLE:    accept = sample && (S8 == 8'd1);
            COUNT:   accept = sample && (same ? ((cnt + 8'd1) == S8) : (S8 == 8'd1));
            HELD:    accept = sample && !same && (S8 == 8'd1);
            default: accept = 1'b0;
        endcase
    end

    // Decode the incoming pattern and precompute the shadow/pending updates.
    always_comb begin
        {dec_ok, dec_nib}            = decode(seg_al);
        shadow_next                  = shadow;
        shadow_next[4*seg_idx +: 4]  = dec_nib;
        pend_set                     = pending;
        pend_set[seg_idx]            = 1'b1;
        pend_clr                     = pending;
        pend_clr[seg_idx]            = 1'b0;
    end

    // Debounce FSM plus frame assembly; all outputs registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            cur_idx     <= '0;
            cur_seg     <= '0;
            shadow      <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_idx     <= '0;
            pending     <= '0;
        end else begin
            frame_valid <= 1'b0;
            err         <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample) begin
                        cur_idx <= seg_idx;
                        cur_seg <= seg_al;
                        cnt     <= 8'd1;
                        state   <= (S8 == 8'd1) ? HELD : COUNT;
                    end
                end
                COUNT, HELD: begin
                    if (!sample) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else if (same) begin
                        if (state == COUNT) begin
                            cnt <= cnt + 8'd1;
                            if ((cnt + 8'd1) == S8)
                                state <= HELD;
                        end
                    end else begin
                        cur_idx <= seg_idx;
                        cur_seg <= seg_al;
                        cnt     <= 8'd1;
                        state   <= (S8 == 8'd1) ? HELD : COUNT;
                    end
                end
                default: begin
                    cnt   <= 8'd0;
                    state <= IDLE;
                end
            endcase

            if (accept) begin
                if (dec_ok) begin
                    shadow <= shadow_next;
                    if (&pend_set) begin
                        value       <= shadow_next;
                        frame_valid <= 1'b1;
                        pending     <= '0;
                    end else begin
                        pending <= pend_set;
                    end
                end else begin
                    err     <= 1'b1;
                    err_idx <= seg_idx;
                    pending <= pend_clr;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a DIGITS=4/S=4 instance for the main
// scenarios and a DIGITS=2/S=1 instance for the single-cycle accept case.
// Patterns are written in active-low form and converted when
// SEG7_CAPTURE_CC_EN is defined.
module tb_seg7_capture;

    logic        clk;
    logic        rst;

    logic        seg_valid;
    logic [1:0]  seg_idx;
    logic [6:0]  seg_n;
    logic [15:0] value;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_idx;
    logic [3:0]  pending;

    logic        seg_valid2;
    logic [0:0]  seg_idx2;
    logic [6:0]  seg_n2;
    logic [7:0]  value2;
    logic        frame_valid2;
    logic        err2;
    logic [0:0]  err_idx2;
    logic [1:0]  pending2;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int err_cnt = 0;

    seg7_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .seg_valid(seg_valid), .seg_idx(seg_idx),
        .seg_n(seg_n), .value(value), .frame_valid(frame_valid), .err(err),
        .err_idx(err_idx), .pending(pending)
    );

    seg7_capture #(.DIGITS(2), .STABLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .seg_valid(seg_valid2), .seg_idx(seg_idx2),
        .seg_n(seg_n2), .value(value2), .frame_valid(frame_valid2), .err(err2),
        .err_idx(err_idx2), .pending(pending2)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1);
    end

    // pulse monitor on the opposite edge
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    function automatic logic [6:0] pat(input logic [6:0] al);
`ifdef SEG7_CAPTURE_CC_EN
        return ~al;
`else
        return al;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [1:0] idx, input logic [6:0] al, input int n);
        seg_valid = v;
        seg_idx   = idx;
        seg_n     = pat(al);
        repeat (n) step();
    endtask

    task automatic present2(input logic v, input logic [0:0] idx, input logic [6:0] al, input int n);
        seg_valid2 = v;
        seg_idx2   = idx;
        seg_n2     = pat(al);
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        seg_valid = 1'b0; seg_idx = '0; seg_n = 7'h7F;
        seg_valid2 = 1'b0; seg_idx2 = '0; seg_n2 = 7'h7F;
        #12;
        checks++; if (value !== 16'h0) begin errors++; $display("FAIL rst_value: got %h expected 0000", value); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_fv: got %b expected 0", frame_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        checks++; if (err_idx !== 2'd0) begin errors++; $display("FAIL rst_err_idx: got %0d expected 0", err_idx); end
        checks++; if (pending !== 4'b0) begin errors++; $display("FAIL rst_pending: got %b expected 0000", pending); end
        checks++; if (value2 !== 8'h0) begin errors++; $display("FAIL rst_value2: got %h expected 00", value2); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_frame();
        int fv0;
        fv0 = fv_cnt;
        present(1'b1, 2'd0, 7'b0000001, 4);
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL frame_pend0: got %b expected 0001", pending); end
        present(1'b1, 2'd1, 7'b1001111, 4);
        present(1'b1, 2'd2, 7'b0010010, 4);
        present(1'b1, 2'd3, 7'b0000110, 4);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL frame_fv: got %b expected 1", frame_valid); end
        checks++; if (value !== 16'h3210) begin errors++; $display("FAIL frame_value: got %h expected 3210", value); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL frame_pend: got %b expected 0000", pending); end
        present(1'b0, 2'd0, 7'b1111111, 1);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL frame_fv_pulse: got %b expected 0", frame_valid); end
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL frame_fv_count: got %0d expected 1", fv_cnt - fv0); end
    endtask

    task automatic test_short();
        int fv0;
        fv0 = fv_cnt;
        present(1'b1, 2'd0, 7'b0000001, 4);
        present(1'b1, 2'd1, 7'b1001111, 3);
        present(1'b1, 2'd2, 7'b0010010, 4);
        present(1'b0, 2'd0, 7'b1111111, 1);
        checks++; if (pending !== 4'b0101) begin errors++; $display("FAIL short_pend: got %b expected 0101", pending); end
        checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL short_fv: got %0d expected 0", fv_cnt - fv0); end
        checks++; if (value !== 16'h3210) begin errors++; $display("FAIL short_value: got %h expected 3210", value); end
    endtask

    task automatic test_err();
        int e0;
        e0 = err_cnt;
        present(1'b1, 2'd2, 7'b1111111, 4);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", err); end
        checks++; if (err_idx !== 2'd2) begin errors++; $display("FAIL err_idx: got %0d expected 2", err_idx); end
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL err_pend: got %b expected 0001", pending); end
        present(1'b0, 2'd0, 7'b1111111, 1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_len: got %b expected 0", err); end
        present(1'b1, 2'd2, 7'b0111000, 4);
        checks++; if (pending !== 4'b0101) begin errors++; $display("FAIL err_recover: got %b expected 0101", pending); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL err_count: got %0d expected 1", err_cnt - e0); end
    endtask

    task automatic test_hold_long();
        int fv0;
        fv0 = fv_cnt;
        present(1'b1, 2'd1, 7'b1001100, 4);
        present(1'b1, 2'd3, 7'b0000000, 20);
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL hold_pend: got %b expected 0000", pending); end
        checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL hold_fv_count: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (value !== 16'h8F40) begin errors++; $display("FAIL hold_value: got %h expected 8f40", value); end
        present(1'b1, 2'd3, 7'b0000100, 4);
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL hold_reaccept: got %b expected 1000", pending); end
        present(1'b1, 2'd0, 7'b0001000, 4);
        present(1'b1, 2'd1, 7'b1100000, 4);
        present(1'b1, 2'd2, 7'b0110001, 4);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL hold_fv2: got %b expected 1", frame_valid); end
        checks++; if (value !== 16'h9CBA) begin errors++; $display("FAIL hold_overwrite: got %h expected 9cba", value); end
    endtask

    task automatic test_drop();
        present(1'b0, 2'd0, 7'b1111111, 1);
        present(1'b1, 2'd0, 7'b1000010, 3);
        present(1'b0, 2'd0, 7'b1000010, 1);
        present(1'b1, 2'd0, 7'b1000010, 3);
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL drop_restart: got %b expected 0000", pending); end
        present(1'b1, 2'd0, 7'b1000010, 1);
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL drop_accept: got %b expected 0001", pending); end
        present(1'b1, 2'd1, 7'b0110000, 4);
        present(1'b0, 2'd1, 7'b0110000, 1);
        checks++; if (pending !== 4'b0011) begin errors++; $display("FAIL drop_keep: got %b expected 0011", pending); end
    endtask

    task automatic test_async_reset();
        int fv0;
        present(1'b1, 2'd2, 7'b0100000, 4);
        checks++; if (pending !== 4'b0111) begin errors++; $display("FAIL ar_pre: got %b expected 0111", pending); end
        #3 rst = 1'b1;
        #1;
        checks++; if (value !== 16'h0) begin errors++; $display("FAIL ar_value: got %h expected 0000", value); end
        checks++; if (pending !== 4'b0) begin errors++; $display("FAIL ar_pend: got %b expected 0000", pending); end
        #2 rst = 1'b0;
        fv0 = fv_cnt;
        present(1'b1, 2'd3, 7'b0001111, 4);
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL ar_pend2: got %b expected 1000", pending); end
        present(1'b1, 2'd0, 7'b1001111, 4);
        present(1'b1, 2'd1, 7'b0010010, 4);
        checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL ar_nofv: got %0d expected 0", fv_cnt - fv0); end
        present(1'b1, 2'd2, 7'b0100100, 4);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ar_fv: got %b expected 1", frame_valid); end
        checks++; if (value !== 16'h7521) begin errors++; $display("FAIL ar_value2: got %h expected 7521", value); end
        present(1'b0, 2'd0, 7'b1111111, 1);
    endtask

    task automatic test_single_cycle();
        present2(1'b1, 1'd0, 7'b0001000, 1);
        checks++; if (pending2 !== 2'b01) begin errors++; $display("FAIL s1_pend: got %b expected 01", pending2); end
        checks++; if (frame_valid2 !== 1'b0) begin errors++; $display("FAIL s1_nofv: got %b expected 0", frame_valid2); end
        present2(1'b1, 1'd1, 7'b1100000, 1);
        checks++; if (frame_valid2 !== 1'b1) begin errors++; $display("FAIL s1_fv: got %b expected 1", frame_valid2); end
        checks++; if (value2 !== 8'hBA) begin errors++; $display("FAIL s1_value: got %h expected ba", value2); end
        present2(1'b1, 1'd0, 7'b0110001, 1);
        checks++; if (frame_valid2 !== 1'b0) begin errors++; $display("FAIL s1_fv_pulse: got %b expected 0", frame_valid2); end
        present2(1'b1, 1'd1, 7'b1000010, 1);
        checks++; if (value2 !== 8'hDC) begin errors++; $display("FAIL s1_value2: got %h expected dc", value2); end
        present2(1'b1, 1'd1, 7'b1000010, 2);
        checks++; if (pending2 !== 2'b00) begin errors++; $display("FAIL s1_held: got %b expected 00", pending2); end
        present2(1'b0, 1'd0, 7'b1111111, 1);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_short();
        test_err();
        test_hold_long();
        test_drop();
        test_async_reset();
        test_single_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the hex-to-7-segment display decoder. Samples a time-multiplexed, active-low 7-segment digit bus of the kind driven to the board displays, debounces each pattern, and maps it back to a 4-bit value. Assembles one nibble per digit position into a multi-digit word. Used on the loopback and readback path so counter results driven to the displays can be checked in-system.

## Interface
Parameters:
- DIGITS, 4: digit positions per frame (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required to accept a digit (1..255).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- seg_valid  in  1  seg_n/seg_idx carry a digit this cycle.
- seg_idx  in  $clog2(DIGITS) (min 1)  digit position of the current pattern.
- seg_n  in  7  segments {a,b,c,d,e,f,g}; 0 = lit.
- value  out  4*DIGITS  last complete frame; digit i at [4i+3:4i].
- frame_valid  out  1  one-cycle pulse when value updates.
- err  out  1  one-cycle pulse on an accepted but undecodable pattern.
- err_idx  out  $clog2(DIGITS) (min 1)  position of the last error.
- pending  out  DIGITS  positions captured so far in the current frame.

## Operation
- Tuple = {seg_idx, seg_n}. A sample counts only when seg_valid=1 and seg_idx<DIGITS. Otherwise it is treated as seg_valid=0.
- FSM states:
  - IDLE: counter 0. A counting sample -> COUNT, cnt=1.
  - COUNT: same tuple -> cnt+1. Different tuple -> cnt=1 with the new tuple. No sample -> IDLE.
  - When cnt reaches STABLE_CYCLES, the digit is accepted -> HELD.
  - HELD: same tuple -> stay, no re-accept. Different tuple -> COUNT, cnt=1. No sample -> IDLE.
- Decode, segment patterns abcdefg -> value:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->b
  - 0110001->C, 1000010->d, 0110000->E, 0111000->F
  - Any other pattern, including all-off 1111111, is invalid.
- On accept with a valid pattern:
  - Write the nibble to shadow slot seg_idx and set pending[seg_idx].
  - Re-accepting a slot overwrites it.
- On accept with an invalid pattern:
  - err=1, err_idx=seg_idx.
  - Clear pending[seg_idx]; the shadow slot keeps its old value.
- Frame completion: when an accept makes pending all ones:
  - value <= shadow, including the just-accepted nibble.
  - frame_valid=1.
  - pending <= 0.
- An error on the final missing digit yields no frame.
- With STABLE_CYCLES=1, every change of tuple is accepted on its first edge.

## Timing
- Reset values: value=0, frame_valid=0, err=0, err_idx=0, pending=0, shadow=0, cnt=0, state IDLE.
- Reset mid-count discards partial frame and counter.
- All outputs are registered. A tuple presented on edges k..k+S-1 (S=STABLE_CYCLES) is accepted at edge k+S-1.
  - err, frame_valid, value and pending reflect the accept in the cycle after that edge.
- Pulses last exactly one cycle. Back-to-back frames may pulse frame_valid on consecutive accepts.
- cnt saturates at STABLE_CYCLES; an 8-bit counter suffices.
- A one-cycle seg_valid drop restarts counting from IDLE. It does not clear pending.

## Configuration
- SEG7_CAPTURE_CC_EN defined: seg_n is treated as active-high (common cathode). The input is inverted before both comparison and decode, so 1111110->0 and so on.
- Undefined: active-low (common anode) decode as tabled above.

## Test plan
- S=4, DIGITS=4; idx 0..3 carry 0000001, 1001111, 0010010, 0000110, each held 4 cycles -> one frame_valid pulse, value=16'h3210, pending=0 after.
- Pattern for idx 1 held only 3 cycles, then idx 2 -> idx 1 not in pending, no frame_valid.
- idx 2 held with 1111111 for 4 cycles -> err pulse, err_idx=2, pending[2]=0; then idx 2 with 0111000 -> pending[2]=1.
- Same tuple held 20 cycles -> exactly one accept; change segments on the same idx -> second accept after 4 more cycles overwrites the nibble.
- rst asserted asynchronously after 3 of 4 digits captured -> all outputs 0 immediately; the next full frame is required before frame_valid.
- With SEG7_CAPTURE_CC_EN, S=1: 1110111 then 0011111 on idx 0/1 (DIGITS=2) -> value=8'hBA, frame_valid on the second accept.
